// File: rtl/scramble_pkg.sv
// -----------------------------------------------------------------------------
// scramble_pkg
// Shared definitions for the arcade_dial block:
//   - Gray-code quadrature phase constants and the phase-advance function
//   - direction encoding for a dial channel
//   - step_width(): number of bits needed to hold a step of 1..accel_max
// -----------------------------------------------------------------------------
package scramble_pkg;

    // Quadrature phases in forward (increment) order.
    localparam logic [1:0] GRAY_PH0 = 2'b00;
    localparam logic [1:0] GRAY_PH1 = 2'b01;
    localparam logic [1:0] GRAY_PH2 = 2'b11;
    localparam logic [1:0] GRAY_PH3 = 2'b10;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    function automatic int step_width(input int accel_max);
        return $clog2(accel_max + 1);
    endfunction

    // One Gray phase forward (up = 1) or backward (up = 0).
    function automatic logic [1:0] gray_next(input logic [1:0] cur, input logic up);
        logic [1:0] nxt;
        case (cur)
            GRAY_PH0: nxt = up ? GRAY_PH1 : GRAY_PH3;
            GRAY_PH1: nxt = up ? GRAY_PH2 : GRAY_PH0;
            GRAY_PH2: nxt = up ? GRAY_PH3 : GRAY_PH1;
            default:  nxt = up ? GRAY_PH0 : GRAY_PH2;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/arcade_dial_chan.sv
// -----------------------------------------------------------------------------
// arcade_dial_chan
// One dial channel: position register with acceleration ramp, wrap/clamp
// arithmetic, quadrature phase output and a moved pulse.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   tick                 shared movement tick (one cycle wide)
//   saturate             0 = wrap, 1 = clamp (only looked at on a tick)
//   move_left/move_right direction request levels
//   load, load_val       synchronous position load (wins over a tick)
//   dial                 registered position
//   quad                 registered Gray quadrature phase
//   moved                one-cycle pulse whenever dial changed
// -----------------------------------------------------------------------------
module arcade_dial_chan
    import scramble_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int ACCEL_TICKS = 8,
    parameter int ACCEL_MAX   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             saturate,
    input  logic             move_left,
    input  logic             move_right,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] dial,
    output logic [1:0]       quad,
    output logic             moved
);

    localparam int STEP_W = step_width(ACCEL_MAX);
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);
    // Two guard bits: one for the sign, one for overflow past 2^WIDTH-1.
    localparam int EXT_W  = WIDTH + 2;

    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(ACCEL_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACCEL_TICKS - 1);
    localparam logic signed [EXT_W-1:0] POS_MAX = {2'b00, {WIDTH{1'b1}}};

    logic [WIDTH-1:0]  pos_q,   pos_d;
    logic [1:0]        quad_q,  quad_d;
    logic              moved_q, moved_d;
    logic [STEP_W-1:0] step_q,  step_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    dir_e              dir_q,   dir_d;

    dir_e              dir_now;
    logic              same_dir;
    logic [STEP_W-1:0] eff_step;
    logic [HOLD_W-1:0] eff_hold;

    // New position after moving by step; wraps modulo 2^WIDTH or clamps.
    function automatic logic [WIDTH-1:0] next_pos(
        input logic [WIDTH-1:0]  pos,
        input logic [STEP_W-1:0] step,
        input logic              down,
        input logic              clamp
    );
        logic signed [EXT_W-1:0] pos_ext;
        logic signed [EXT_W-1:0] step_ext;
        logic signed [EXT_W-1:0] sum;
        logic [WIDTH-1:0]        res;
        pos_ext  = $signed({2'b00, pos});
        step_ext = $signed({{(EXT_W-STEP_W){1'b0}}, step});
        sum      = down ? (pos_ext - step_ext) : (pos_ext + step_ext);
        if (!clamp) begin
            res = sum[WIDTH-1:0];
        end else if (sum[EXT_W-1]) begin
            res = '0;
        end else if (sum > POS_MAX) begin
            res = '1;
        end else begin
            res = sum[WIDTH-1:0];
        end
        return res;
    endfunction

    always_comb begin
        if (move_right && !move_left) begin
            dir_now = DIR_UP;
        end else if (move_left && !move_right) begin
            dir_now = DIR_DOWN;
        end else begin
            dir_now = DIR_IDLE;
        end
    end

    // A change of direction (including starting from idle) restarts the ramp;
    // that first tick moves by 1 and already counts as one held tick.
    assign same_dir = (dir_now == dir_q);
    assign eff_step = same_dir ? step_q : STEP_ONE;
    assign eff_hold = same_dir ? hold_q : '0;

    always_comb begin
        pos_d   = pos_q;
        quad_d  = quad_q;
        moved_d = 1'b0;
        step_d  = step_q;
        hold_d  = hold_q;
        dir_d   = dir_q;

        if (load) begin
            // Load wins over a coincident tick and leaves the phase alone.
            pos_d   = load_val;
            moved_d = (load_val != pos_q);
            step_d  = STEP_ONE;
            hold_d  = '0;
            dir_d   = DIR_IDLE;
        end else if (tick) begin
            if (dir_now == DIR_IDLE) begin
                step_d = STEP_ONE;
                hold_d = '0;
                dir_d  = DIR_IDLE;
            end else begin
                pos_d   = next_pos(pos_q, eff_step, dir_now == DIR_DOWN, saturate);
                moved_d = (pos_d != pos_q);
                // Phase follows the request even when clamped at an end.
                quad_d  = gray_next(quad_q, dir_now == DIR_UP);
                dir_d   = dir_now;
                if (eff_hold == HOLD_LAST) begin
                    hold_d = '0;
                    step_d = (eff_step == STEP_MAX) ? eff_step : (eff_step + STEP_ONE);
                end else begin
                    hold_d = eff_hold + HOLD_W'(1);
                    step_d = eff_step;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q   <= '0;
            quad_q  <= GRAY_PH0;
            moved_q <= 1'b0;
            step_q  <= STEP_ONE;
            hold_q  <= '0;
            dir_q   <= DIR_IDLE;
        end else begin
            pos_q   <= pos_d;
            quad_q  <= quad_d;
            moved_q <= moved_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
        end
    end

    assign dial  = pos_q;
    assign quad  = quad_q;
    assign moved = moved_q;

endmodule

// File: rtl/arcade_dial.sv
// -----------------------------------------------------------------------------
// arcade_dial
// Multi-channel arcade dial emulator. A shared prescaler produces a movement
// tick every PRESCALE clocks; each channel moves its position on that tick
// according to its left/right request, with acceleration while held.
//
// Ports:
//   clk         system clock (rising edge)
//   RESET_N     asynchronous active-low reset
//   move_left   [CHANNELS]        per-channel decrement request
//   move_right  [CHANNELS]        per-channel increment request
//   saturate                      0 = wrap, 1 = clamp
//   load        [CHANNELS]        per-channel position load strobe
//   load_val    [WIDTH]           value written by load
//   dial        [CHANNELS*WIDTH]  positions, channel n at [n*WIDTH +: WIDTH]
//   quad        [2*CHANNELS]      Gray phase, channel n at [2*n +: 2]
//   moved       [CHANNELS]        one-cycle pulse when a position changed
// -----------------------------------------------------------------------------
module arcade_dial
    import scramble_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 5,
    parameter int PRESCALE    = 1200,
    parameter int ACCEL_TICKS = 8,
    parameter int ACCEL_MAX   = 4
) (
    input  logic                      clk,
    input  logic                      RESET_N,
    input  logic [CHANNELS-1:0]       move_left,
    input  logic [CHANNELS-1:0]       move_right,
    input  logic                      saturate,
    input  logic [CHANNELS-1:0]       load,
    input  logic [WIDTH-1:0]          load_val,
    output logic [CHANNELS*WIDTH-1:0] dial,
    output logic [2*CHANNELS-1:0]     quad,
    output logic [CHANNELS-1:0]       moved
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    // Down-counter; tick is high for the single cycle the count sits at 0.
    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = tick ? CNT_RELOAD : (cnt_q - CNT_W'(1));
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= CNT_RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        arcade_dial_chan #(
            .WIDTH       (WIDTH),
            .ACCEL_TICKS (ACCEL_TICKS),
            .ACCEL_MAX   (ACCEL_MAX)
        ) u_chan (
            .clk        (clk),
            .rst_n      (RESET_N),
            .tick       (tick),
            .saturate   (saturate),
            .move_left  (move_left[n]),
            .move_right (move_right[n]),
            .load       (load[n]),
            .load_val   (load_val),
            .dial       (dial[n*WIDTH +: WIDTH]),
            .quad       (quad[2*n +: 2]),
            .moved      (moved[n])
        );
    end

endmodule

// File: tb/tb_arcade_dial.sv
// -----------------------------------------------------------------------------
// tb_arcade_dial
// Directed bench for arcade_dial with PRESCALE=4, ACCEL_TICKS=2, ACCEL_MAX=3,
// WIDTH=5, CHANNELS=2. Stimulus is kept aligned to the 4-cycle tick grid
// that starts at reset release.
// -----------------------------------------------------------------------------
module tb_arcade_dial;

    localparam int CHANNELS    = 2;
    localparam int WIDTH       = 5;
    localparam int PRESCALE    = 4;
    localparam int ACCEL_TICKS = 2;
    localparam int ACCEL_MAX   = 3;

    logic                      clk = 1'b0;
    logic                      RESET_N;
    logic [CHANNELS-1:0]       move_left;
    logic [CHANNELS-1:0]       move_right;
    logic                      saturate;
    logic [CHANNELS-1:0]       load;
    logic [WIDTH-1:0]          load_val;
    logic [CHANNELS*WIDTH-1:0] dial;
    logic [2*CHANNELS-1:0]     quad;
    logic [CHANNELS-1:0]       moved;

    int checks = 0;
    int passes = 0;
    int q0n    = 0;   // net forward phase steps of channel 0
    int q1n    = 0;   // net forward phase steps of channel 1

    logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    arcade_dial #(
        .CHANNELS    (CHANNELS),
        .WIDTH       (WIDTH),
        .PRESCALE    (PRESCALE),
        .ACCEL_TICKS (ACCEL_TICKS),
        .ACCEL_MAX   (ACCEL_MAX)
    ) dut (
        .clk        (clk),
        .RESET_N    (RESET_N),
        .move_left  (move_left),
        .move_right (move_right),
        .saturate   (saturate),
        .load       (load),
        .load_val   (load_val),
        .dial       (dial),
        .quad       (quad),
        .moved      (moved)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [1:0] gray_of(input int n);
        return gray_tab[((n % 4) + 4) % 4];
    endfunction

    // Advance one full tick period; the tick's update is visible on return.
    task automatic step_tick();
        repeat (PRESCALE) @(posedge clk);
        #1;
    endtask

    // Load on the first edge of a tick period, then finish the period.
    task automatic load_window(input int ch, input logic [WIDTH-1:0] val);
        load[ch] = 1'b1;
        load_val = val;
        @(posedge clk);
        #1;
        load = '0;
        repeat (PRESCALE-1) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RESET_N    = 1'b0;
        move_left  = '0;
        move_right = '0;
        saturate   = 1'b0;
        load       = '0;
        load_val   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dial !== '0) $display("FAIL reset_dial: got %h want 0", dial); else passes++;
        checks++; if (quad !== '0) $display("FAIL reset_quad: got %b want 0", quad); else passes++;
        checks++; if (moved !== '0) $display("FAIL reset_moved: got %b want 0", moved); else passes++;
        @(negedge clk);
        RESET_N = 1'b1;
        // No movement before the fourth edge after release, even with a request.
        move_right = 2'b01;
        repeat (PRESCALE-1) @(posedge clk);
        #1;
        checks++; if (dial[4:0] !== 5'd0) $display("FAIL reset_first_tick_early: got %0d want 0", dial[4:0]); else passes++;
        @(posedge clk);
        #1;
        q0n++;
        checks++; if (dial[4:0] !== 5'd1) $display("FAIL reset_first_tick: got %0d want 1", dial[4:0]); else passes++;
    endtask

    task automatic test_accel();
        int exp_pos [6] = '{1, 2, 4, 6, 9, 12};
        // First of the six ticks already happened at the end of test_reset.
        checks++; if (moved[0] !== 1'b1) $display("FAIL accel_moved[0]: got %b want 1", moved[0]); else passes++;
        for (int i = 1; i < 6; i++) begin
            step_tick();
            q0n++;
            checks++; if (dial[4:0] !== 5'(exp_pos[i])) $display("FAIL accel_dial[%0d]: got %0d want %0d", i, dial[4:0], exp_pos[i]); else passes++;
            checks++; if (moved[0] !== 1'b1) $display("FAIL accel_moved[%0d]: got %b want 1", i, moved[0]); else passes++;
        end
        checks++; if (quad[1:0] !== gray_of(q0n)) $display("FAIL accel_quad: got %b want %b", quad[1:0], gray_of(q0n)); else passes++;
        move_right = '0;
        step_tick();
        checks++; if (dial[4:0] !== 5'd12) $display("FAIL accel_idle_dial: got %0d want 12", dial[4:0]); else passes++;
        checks++; if (moved[0] !== 1'b0) $display("FAIL accel_idle_moved: got %b want 0", moved[0]); else passes++;
    endtask

    task automatic test_wrap_clamp();
        int exp_w [5] = '{25, 26, 28, 30, 1};
        int exp_c [5] = '{25, 26, 28, 30, 31};
        saturate = 1'b0;
        load_window(0, 5'd24);
        checks++; if (dial[4:0] !== 5'd24) $display("FAIL wrap_load: got %0d want 24", dial[4:0]); else passes++;
        move_right = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step_tick();
            q0n++;
            checks++; if (dial[4:0] !== 5'(exp_w[i])) $display("FAIL wrap_dial[%0d]: got %0d want %0d", i, dial[4:0], exp_w[i]); else passes++;
        end
        checks++; if (quad[1:0] !== gray_of(q0n)) $display("FAIL wrap_quad: got %b want %b", quad[1:0], gray_of(q0n)); else passes++;

        move_right = '0;
        saturate   = 1'b1;
        load_window(0, 5'd24);
        checks++; if (dial[4:0] !== 5'd24) $display("FAIL clamp_load: got %0d want 24", dial[4:0]); else passes++;
        move_right = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step_tick();
            q0n++;
            checks++; if (dial[4:0] !== 5'(exp_c[i])) $display("FAIL clamp_dial[%0d]: got %0d want %0d", i, dial[4:0], exp_c[i]); else passes++;
        end
        checks++; if (moved[0] !== 1'b1) $display("FAIL clamp_moved_last: got %b want 1", moved[0]); else passes++;
        for (int i = 0; i < 2; i++) begin
            step_tick();
            q0n++;
            checks++; if (dial[4:0] !== 5'd31) $display("FAIL clamp_hold_dial[%0d]: got %0d want 31", i, dial[4:0]); else passes++;
            checks++; if (moved[0] !== 1'b0) $display("FAIL clamp_hold_moved[%0d]: got %b want 0", i, moved[0]); else passes++;
            checks++; if (quad[1:0] !== gray_of(q0n)) $display("FAIL clamp_quad[%0d]: got %b want %b", i, quad[1:0], gray_of(q0n)); else passes++;
        end
        move_right = '0;
        saturate   = 1'b0;
    endtask

    task automatic test_both();
        int exp_r [3] = '{11, 12, 14};
        load_window(1, 5'd10);
        checks++; if (dial[9:5] !== 5'd10) $display("FAIL both_load: got %0d want 10", dial[9:5]); else passes++;
        checks++; if (quad[3:2] !== 2'b00) $display("FAIL both_load_quad: got %b want 00", quad[3:2]); else passes++;
        move_right = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step_tick();
            q1n++;
            checks++; if (dial[9:5] !== 5'(exp_r[i])) $display("FAIL both_ramp[%0d]: got %0d want %0d", i, dial[9:5], exp_r[i]); else passes++;
        end
        move_left = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step_tick();
            checks++; if (dial[9:5] !== 5'd14) $display("FAIL both_dial[%0d]: got %0d want 14", i, dial[9:5]); else passes++;
            checks++; if (moved[1] !== 1'b0) $display("FAIL both_moved[%0d]: got %b want 0", i, moved[1]); else passes++;
            checks++; if (quad[3:2] !== gray_of(q1n)) $display("FAIL both_quad[%0d]: got %b want %b", i, quad[3:2], gray_of(q1n)); else passes++;
        end
        checks++; if (dial[4:0] !== 5'd31) $display("FAIL both_ch0_indep: got %0d want 31", dial[4:0]); else passes++;
        move_left = '0;
        step_tick();
        q1n++;
        checks++; if (dial[9:5] !== 5'd15) $display("FAIL both_step_reset: got %0d want 15", dial[9:5]); else passes++;
        checks++; if (quad[3:2] !== gray_of(q1n)) $display("FAIL both_resume_quad: got %b want %b", quad[3:2], gray_of(q1n)); else passes++;
        move_right = '0;
    endtask

    task automatic test_load_tick();
        saturate   = 1'b0;
        move_right = 2'b01;
        repeat (PRESCALE-1) @(posedge clk);
        #1;
        load[0]  = 1'b1;
        load_val = 5'd17;
        @(posedge clk);
        #1;
        load = '0;
        checks++; if (dial[4:0] !== 5'd17) $display("FAIL load_tick_dial: got %0d want 17", dial[4:0]); else passes++;
        checks++; if (moved[0] !== 1'b1) $display("FAIL load_tick_moved: got %b want 1", moved[0]); else passes++;
        checks++; if (quad[1:0] !== gray_of(q0n)) $display("FAIL load_tick_quad: got %b want %b", quad[1:0], gray_of(q0n)); else passes++;
        step_tick();
        q0n++;
        checks++; if (dial[4:0] !== 5'd18) $display("FAIL load_next_tick: got %0d want 18", dial[4:0]); else passes++;
    endtask

    task automatic test_reversal();
        int exp_r [8] = '{19, 21, 23, 26, 29, 0, 3, 6};
        for (int i = 0; i < 8; i++) begin
            step_tick();
            q0n++;
            checks++; if (dial[4:0] !== 5'(exp_r[i])) $display("FAIL rev_ramp[%0d]: got %0d want %0d", i, dial[4:0], exp_r[i]); else passes++;
        end
        checks++; if (quad[1:0] !== 2'b10) $display("FAIL rev_quad_before: got %b want 10", quad[1:0]); else passes++;
        move_right = '0;
        move_left  = 2'b01;
        step_tick();
        q0n--;
        checks++; if (dial[4:0] !== 5'd5) $display("FAIL rev_dial: got %0d want 5", dial[4:0]); else passes++;
        checks++; if (quad[1:0] !== 2'b11) $display("FAIL rev_quad_after: got %b want 11", quad[1:0]); else passes++;
        checks++; if (moved[0] !== 1'b1) $display("FAIL rev_moved: got %b want 1", moved[0]); else passes++;
    endtask

    task automatic test_async_reset();
        int exp_l [4] = '{4, 2, 0, 29};
        for (int i = 0; i < 4; i++) begin
            step_tick();
            checks++; if (dial[4:0] !== 5'(exp_l[i])) $display("FAIL areset_ramp[%0d]: got %0d want %0d", i, dial[4:0], exp_l[i]); else passes++;
        end
        @(posedge clk);
        #2;
        RESET_N = 1'b0;
        #1;
        checks++; if (dial !== '0) $display("FAIL areset_dial: got %h want 0", dial); else passes++;
        checks++; if (quad !== '0) $display("FAIL areset_quad: got %b want 0", quad); else passes++;
        checks++; if (moved !== '0) $display("FAIL areset_moved: got %b want 0", moved); else passes++;
        @(posedge clk);
        #2;
        RESET_N = 1'b1;
        repeat (PRESCALE-1) @(posedge clk);
        #1;
        checks++; if (dial[4:0] !== 5'd0) $display("FAIL areset_early: got %0d want 0", dial[4:0]); else passes++;
        @(posedge clk);
        #1;
        checks++; if (dial[4:0] !== 5'd31) $display("FAIL areset_first: got %0d want 31", dial[4:0]); else passes++;
        checks++; if (quad[1:0] !== 2'b10) $display("FAIL areset_first_quad: got %b want 10", quad[1:0]); else passes++;
        checks++; if (moved[0] !== 1'b1) $display("FAIL areset_first_moved: got %b want 1", moved[0]); else passes++;
        step_tick();
        checks++; if (dial[4:0] !== 5'd30) $display("FAIL areset_second: got %0d want 30", dial[4:0]); else passes++;
        move_left = '0;
    endtask

    initial begin
        test_reset();
        test_accel();
        test_wrap_clamp();
        test_both();
        test_load_tick();
        test_reversal();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/arcade_dial.md
ARCADE_DIAL -- requirements
Module: arcade_dial

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent dial channels, 1..4.
REQ-002 SHALL have parameter WIDTH, default 5: position bits per channel, 3..8.
REQ-003 SHALL have parameter PRESCALE, default 1200: clk cycles per movement tick, at least 2.
REQ-004 SHALL have parameter ACCEL_TICKS, default 8: consecutive held ticks per acceleration step.
REQ-005 SHALL have parameter ACCEL_MAX, default 4: maximum step size, 1..7.
REQ-006 SHALL have port clk, input, width 1: single system clock; all logic on its rising edge.
REQ-007 SHALL have port RESET_N, input, width 1: reset, asynchronous, active-low.
REQ-008 SHALL have port move_left, input, width CHANNELS: per-channel decrement request, level.
REQ-009 SHALL have port move_right, input, width CHANNELS: per-channel increment request, level.
REQ-010 SHALL have port saturate, input, width 1: 0 = wrap mode, 1 = clamp mode; sampled at each tick.
REQ-011 SHALL have port load, input, width CHANNELS: per-channel synchronous position load strobe.
REQ-012 SHALL have port load_val, input, width WIDTH: value written by load.
REQ-013 SHALL have port dial, output, width CHANNELS*WIDTH: registered positions; channel n occupies bits [n*WIDTH +: WIDTH].
REQ-014 SHALL have port quad, output, width 2*CHANNELS: registered quadrature A/B phase per channel.
REQ-015 SHALL have port moved, output, width CHANNELS: one-cycle pulse when the position changed this cycle.

Function
REQ-016 SHALL implement a shared prescaler that counts PRESCALE-1 down to 0 and asserts an internal tick for exactly one cycle at 0, then reloads.
REQ-017 SHALL sample a channel's direction at a tick as: right only = +1, left only = -1, both or neither = idle.
REQ-018 SHALL add or subtract the current step (1..ACCEL_MAX) to or from a non-idle channel's position at the tick, with the result visible on dial the following cycle.
REQ-019 SHALL keep a per-channel hold counter that increments each tick in the same direction and, on reaching ACCEL_TICKS, clears to 0 and raises step by 1, capped at ACCEL_MAX.
REQ-020 SHALL reset step to 1 and the hold counter to 0 on an idle tick or a direction reversal; the reversing tick itself moves by 1.
REQ-021 SHALL in wrap mode compute the new position modulo 2^WIDTH.
REQ-022 SHALL in clamp mode limit the new position to the range 0..2^WIDTH-1; a tick that produces no change SHALL NOT pulse moved.
REQ-023 SHALL advance quad one Gray phase per non-idle tick (00,01,11,10 for +; reverse order for -), independent of step size and of clamping.
REQ-024 SHALL give load priority over a simultaneous tick: the position becomes load_val, step and hold reset, quad is unchanged, and moved pulses if the value differs.
REQ-025 SHALL keep channels fully independent, apart from the shared tick.

Reset
REQ-026 SHALL while RESET_N is low clear dial to 0, clear quad to 00, clear moved to 0, set step to 1, clear hold to 0, and load the prescaler with PRESCALE-1.
REQ-027 SHALL on reset mid-ramp discard all acceleration state; the first tick after release occurs PRESCALE cycles later.

Structure
REQ-028 SHALL place the Gray phase constants and the step-width function (clog2 of ACCEL_MAX+1) in a shared package, scramble_pkg.
REQ-029 SHALL instantiate a single per-channel sub-module, arcade_dial_chan, CHANNELS times via a generate loop; the prescaler SHALL reside in the top module.

Verification (PRESCALE=4, ACCEL_TICKS=2, ACCEL_MAX=3, WIDTH=5, CHANNELS=2)
REQ-030 SHALL cover: ch0 right held for 6 ticks in wrap mode from 0 -> dial0 = 1,2,4,6,9,12, with moved pulsing every tick.
REQ-031 SHALL cover: wrap mode, dial0 = 30, right held at step 3 -> dial0 = 1; the same stimulus in clamp mode -> dial0 = 31, then no further moved pulses.
REQ-032 SHALL cover: ch1 left and right both held for 3 ticks -> dial1, quad1 and moved1 are unchanged, and step resets to 1.
REQ-033 SHALL cover: load0 with load_val = 17 coinciding with a tick while right is held -> dial0 = 17, and the next tick gives 18.
REQ-034 SHALL cover: RESET_N pulsed low for 1 cycle asynchronously during a step-3 ramp -> all outputs are 0 immediately, and the first movement occurs 4 cycles after release with step 1.
REQ-035 SHALL cover: reversal from right at step 3 to left -> dial decrements by 1, and quad steps 10 -> 11.
